// File: rtl/future_pkg.sv
// ============================================================================
// Module   : future_pkg
// Brief    : Shared widths and types for the FUTURE round counter slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package future_pkg;

  localparam int ROUNDS_DEFAULT = 10;
  localparam int CNT_W          = 4;

  typedef logic [CNT_W-1:0] round_t;

endpackage : future_pkg

`default_nettype wire

// File: rtl/future_sideband_reg.sv
// ============================================================================
// Module   : future_sideband_reg
// Brief    : Six-bit enabled register that delays the cipher sideband bits by
//            one enabled cycle, with asynchronous active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module future_sideband_reg (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic Xr,
  input  logic X6,
  input  logic K6,
  input  logic K5,
  input  logic C6,
  input  logic sm,
  output logic Yr,
  output logic Y6,
  output logic L6,
  output logic L5,
  output logic D6,
  output logic sm1
);

  logic [5:0] sb_d;
  logic [5:0] sb_q;

  always_comb begin
    sb_d = sb_q;
    if (en) begin
      sb_d = {Xr, X6, K6, K5, C6, sm};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q <= 6'b0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign {Yr, Y6, L6, L5, D6, sm1} = sb_q;

endmodule : future_sideband_reg

`default_nettype wire

// File: rtl/future_round_counter.sv
// ============================================================================
// Module   : future_round_counter
// Brief    : Round index counter with first/last-round decode and aligned
//            sideband delay. Optional macro ROUND_SATURATE_EN makes the count
//            hold at the last round instead of wrapping to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module future_round_counter
  import future_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic B0,
  input  logic B1,
  input  logic Xr,
  input  logic X6,
  input  logic K6,
  input  logic K5,
  input  logic C6,
  input  logic sm,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic C0,
  output logic C1,
  output logic Yr,
  output logic Y6,
  output logic L6,
  output logic L5,
  output logic D6,
  output logic sm1
);

  localparam round_t         LAST       = round_t'(ROUNDS - 1);
  localparam logic [CNT_W:0] ROUNDS_EXT = ROUNDS[CNT_W:0];

  round_t cnt_d;
  round_t cnt_q;
  round_t load_val;
  round_t load_clamped;

  assign load_val     = {b3, b2, b1, b0};
  // Extra MSB in the compare keeps ROUNDS=16 representable.
  assign load_clamped = ({1'b0, load_val} >= ROUNDS_EXT) ? LAST : load_val;

  always_comb begin
    cnt_d = cnt_q;
    if (B1) begin
      cnt_d = '0;
    end else if (B0) begin
      cnt_d = load_clamped;
    end else if (en) begin
      if (cnt_q == LAST) begin
`ifdef ROUND_SATURATE_EN
        cnt_d = LAST;
`else
        cnt_d = '0;
`endif
      end else begin
        cnt_d = cnt_q + round_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign {d3, d2, d1, d0} = cnt_q;
  assign C0 = (cnt_q == LAST);
  assign C1 = (cnt_q == '0);

  future_sideband_reg u_sideband (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .Xr  (Xr),
    .X6  (X6),
    .K6  (K6),
    .K5  (K5),
    .C6  (C6),
    .sm  (sm),
    .Yr  (Yr),
    .Y6  (Y6),
    .L6  (L6),
    .L5  (L5),
    .D6  (D6),
    .sm1 (sm1)
  );

endmodule : future_round_counter

`default_nettype wire

// File: tb/tb_future_round_counter.sv
// ============================================================================
// Module   : tb_future_round_counter
// Brief    : Directed self-checking bench for future_round_counter (ROUNDS=10).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_future_round_counter;

  logic clk = 1'b0;
  logic rst, en, b0, b1, b2, b3, B0, B1;
  logic Xr, X6, K6, K5, C6, sm;
  logic d0, d1, d2, d3, C0, C1;
  logic Yr, Y6, L6, L5, D6, sm1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  future_round_counter #(.ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .en(en),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3), .B0(B0), .B1(B1),
    .Xr(Xr), .X6(X6), .K6(K6), .K5(K5), .C6(C6), .sm(sm),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .C0(C0), .C1(C1),
    .Yr(Yr), .Y6(Y6), .L6(L6), .L5(L5), .D6(D6), .sm1(sm1)
  );

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input int exp);
    check({tag, "_cnt"}, {2'b00, d3, d2, d1, d0}, 6'(exp));
    check({tag, "_C0"}, {5'b0, C0}, {5'b0, (exp == 9)});
    check({tag, "_C1"}, {5'b0, C1}, {5'b0, (exp == 0)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sb(input logic [5:0] v);
    {Xr, X6, K6, K5, C6, sm} = v;
  endtask

  task automatic set_load(input logic [3:0] v);
    {b3, b2, b1, b0} = v;
  endtask

  initial begin
    int exp;
    rst = 1'b0; en = 1'b0; B0 = 1'b0; B1 = 1'b0;
    set_load(4'b0000);
    set_sb(6'b000000);

    // 1. Reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; B0 = i[0]; set_load(4'b0101); set_sb(i[0] ? 6'b111111 : 6'b101010);
      tick();
    end
    check_cnt("reset", 0);
    check("reset_sb", {Yr, Y6, L6, L5, D6, sm1}, 6'b000000);

    rst = 1'b1; en = 1'b1; B0 = 1'b0; set_sb(6'b000000);
    for (int i = 1; i <= 11; i++) begin
      tick();
`ifdef ROUND_SATURATE_EN
      exp = (i > 9) ? 9 : i;
`else
      exp = i % 10;
`endif
      check_cnt($sformatf("run%0d", i), exp);
    end

    // 5. Sideband capture; load wins over increment but not over sideband
    B0 = 1'b1; set_load(4'b0011); set_sb(6'b101101);
    tick();
    check_cnt("load3", 3);
    check("sb_pat", {Yr, Y6, L6, L5, D6, sm1}, 6'b101101);
    B0 = 1'b0; set_sb(6'b010010);
    tick();
    check_cnt("inc4", 4);
    check("sb_pat2", {Yr, Y6, L6, L5, D6, sm1}, 6'b010010);

    // 2. Hold with en=0 while sideband inputs toggle
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_sb(i[0] ? 6'b111111 : 6'b101101);
      tick();
      check_cnt($sformatf("hold%0d", i), 4);
      check($sformatf("hold_sb%0d", i), {Yr, Y6, L6, L5, D6, sm1}, 6'b010010);
    end

    // 3. Loads with en=0, including clamping
    B0 = 1'b1; set_load(4'b0110); tick(); check_cnt("load6", 6);
    set_load(4'b1111); tick(); check_cnt("clamp15", 9);
    set_load(4'b1010); tick(); check_cnt("clamp10", 9);
    set_load(4'b0000); tick(); check_cnt("load0", 0);
    set_load(4'b0111); tick(); check_cnt("load7", 7);

    // 4. Clear beats load
    B1 = 1'b1; set_load(4'b0101); tick(); check_cnt("clr_pri", 0);
    B1 = 1'b0; B0 = 1'b0;
    check("clr_sb", {Yr, Y6, L6, L5, D6, sm1}, 6'b010010);

    // Last-round behaviour from a loaded 8
    B0 = 1'b1; set_load(4'b1000); tick(); check_cnt("load8", 8);
    B0 = 1'b0; en = 1'b1; tick(); check_cnt("to9", 9);
    tick();
`ifdef ROUND_SATURATE_EN
    check_cnt("sat9", 9);
    tick(); check_cnt("sat9b", 9);
    B1 = 1'b1; tick(); check_cnt("sat_clr", 0);
    B1 = 1'b0;
`else
    check_cnt("wrap0", 0);
`endif

    // 6. Asynchronous reset mid-count
    en = 1'b0; B0 = 1'b1; set_load(4'b0101); tick(); check_cnt("load5", 5);
    B0 = 1'b0; en = 1'b1; set_sb(6'b110011); tick(); check_cnt("inc6", 6);
    check("pre_rst_sb", {Yr, Y6, L6, L5, D6, sm1}, 6'b110011);
    en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_cnt("async_rst", 0);
    check("async_rst_sb", {Yr, Y6, L6, L5, D6, sm1}, 6'b000000);
    tick();
    rst = 1'b1; en = 1'b1; set_sb(6'b000000);
    tick(); check_cnt("post_rst", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_future_round_counter

`default_nettype wire
